// File: rtl/ram_stream_reader.sv
// Streams a contiguous block of RAM words out on a valid/ready port.
// A 2-entry buffer hides the one-cycle RAM read latency.
module ram_stream_reader #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] base_index,
  input  logic [INDEX_WIDTH:0]   count,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_read_enable,
  output logic [INDEX_WIDTH-1:0] ram_read_index,
  input  logic [WIDTH-1:0]       ram_read_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last
);

  localparam int CW = INDEX_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          issued_q, issued_d;
  logic [CW-1:0]          sent_q, sent_d;
  logic                   in_flight_q, in_flight_d;
  logic [1:0]             occ_q, occ_d;
  logic                   head_q, head_d;
  logic [WIDTH-1:0]       buf0_q, buf0_d;
  logic [WIDTH-1:0]       buf1_q, buf1_d;

  logic                   pop_s;
  logic                   push_s;
  logic                   issue_s;
  logic                   tail_s;
  logic                   out_valid_s;
  logic                   out_last_s;
  logic [2:0]             room_s;

  assign out_valid_s = (occ_q != 2'd0);
  assign out_last_s  = out_valid_s && (sent_q == (count_q - CNT_ONE));
  assign pop_s       = out_valid_s && out_ready;
  // A read in flight always lands in the buffer; the RAM data is ignored otherwise.
  assign push_s      = in_flight_q;
  assign tail_s      = head_q ^ occ_q[0];
  assign room_s      = {1'b0, occ_q} + {2'b00, in_flight_q};
  assign issue_s     = (state_q == ST_STREAM) && (issued_q < count_q) &&
                       (room_s < (3'd2 + {2'b00, pop_s}));

  assign busy            = (state_q == ST_STREAM);
  assign done            = (state_q == ST_DONE);
  assign ram_read_enable = issue_s;
  assign ram_read_index  = issue_s ? (base_q + issued_q[INDEX_WIDTH-1:0]) : {INDEX_WIDTH{1'b0}};
  assign out_valid       = out_valid_s;
  assign out_last        = out_last_s;
  assign out_data        = out_valid_s ? (head_q ? buf1_q : buf0_q) : {WIDTH{1'b0}};

  // Command FSM plus issue/delivery counters.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issue_s ? (issued_q + CNT_ONE) : issued_q;
    sent_d      = pop_s ? (sent_q + CNT_ONE) : sent_q;
    in_flight_d = issue_s;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_index;
          count_d  = count;
          issued_d = CNT_ZERO;
          sent_d   = CNT_ZERO;
          if (count == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (pop_s && out_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Two-entry circular buffer: push at tail, pop at head, both may happen together.
  always_comb begin
    occ_d  = occ_q + {1'b0, push_s} - {1'b0, pop_s};
    head_d = pop_s ? ~head_q : head_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (push_s) begin
      if (tail_s) begin
        buf1_d = ram_read_data;
      end else begin
        buf0_d = ram_read_data;
      end
    end else begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= {INDEX_WIDTH{1'b0}};
      count_q     <= CNT_ZERO;
      issued_q    <= CNT_ZERO;
      sent_q      <= CNT_ZERO;
      in_flight_q <= 1'b0;
      occ_q       <= 2'd0;
      head_q      <= 1'b0;
      buf0_q      <= {WIDTH{1'b0}};
      buf1_q      <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      in_flight_q <= in_flight_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

endmodule
